key_event_queue: RTL and testbench

- Buffers PS/2 key events from the mist_io `ps2_key` bus and delivers them to the rememotech keyboard inputs (`key_ready`/`key_stroke`/`key_code`).
- Replaces the bare toggle-to-strobe logic at top level.
- Paces deliveries so the emulated MTX keyboard scan sees every event.
- Absorbs bursts, e.g. extended-key sequences or fast typing, without loss.

---
 rtl/key_event_queue.sv | 162 ++++++++++++++++
 tb/tb_key_event_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// PS/2 key event FIFO with paced one-cycle delivery strobes for the MTX keyboard inputs.
// Optional typematic-repeat suppression when KEY_REPEAT_FILTER_EN is defined.
module key_event_queue #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned GAP_CYCLES = 25000
) (
  input  logic                  clk_sys,
  input  logic                  res_n,
  input  logic                  flush,
  input  logic [10:0]           ps2_key,
  output logic                  key_ready,
  output logic                  key_stroke,
  output logic [9:0]            key_code,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned GW    = $clog2(GAP_CYCLES + 1);
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {S_IDLE, S_GAP} state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [10:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  armed_q, prev_tgl_q, overflow_q;
  logic                  key_ready_q, key_ready_d;
  logic                  key_stroke_q, key_stroke_d;
  logic [9:0]            key_code_q, key_code_d;
  logic                  event_det, accept, full, pop, push;
  logic [10:0]           entry;

  assign event_det = armed_q && !flush && (ps2_key[10] != prev_tgl_q);
  assign entry     = {~ps2_key[9], 1'b0, ps2_key[8:0]};
  assign full      = (count_q == FULL_LVL);
  assign pop       = !flush && (state_q == S_IDLE) && (count_q != '0);
  assign push      = accept && (!full || pop);

`ifdef KEY_REPEAT_FILTER_EN
  logic       held_valid_q;
  logic [8:0] held_code_q;

  // Repeated makes of the key already held are dropped before the FIFO sees them.
  assign accept = event_det && !(ps2_key[9] && held_valid_q && (held_code_q == ps2_key[8:0]));

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
    end else if (flush) begin
      held_valid_q <= 1'b0;
    end else if (event_det) begin
      if (ps2_key[9]) begin
        if (accept) begin
          held_code_q  <= ps2_key[8:0];
          held_valid_q <= 1'b1;
        end
      end else if (held_valid_q && (held_code_q == ps2_key[8:0])) begin
        held_valid_q <= 1'b0;
      end
    end
  end
`else
  assign accept = event_det;
`endif

  // First edge after reset/flush only captures the toggle phase.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      armed_q    <= 1'b0;
      prev_tgl_q <= 1'b0;
    end else if (flush) begin
      armed_q <= 1'b0;
    end else if (!armed_q) begin
      armed_q    <= 1'b1;
      prev_tgl_q <= ps2_key[10];
    end else if (event_det) begin
      prev_tgl_q <= ps2_key[10];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (accept && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_q      <= S_IDLE;
      gap_q        <= '0;
      key_ready_q  <= 1'b0;
      key_stroke_q <= 1'b0;
      key_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      key_ready_q  <= key_ready_d;
      key_stroke_q <= key_stroke_d;
      key_code_q   <= key_code_d;
    end
  end

  // GAP returns to IDLE as the counter reaches zero, so pops are exactly GAP_CYCLES apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (flush) begin
      state_d = S_IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop && (GAP_CYCLES > 1)) begin
            state_d = S_GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end
        end
        S_GAP: begin
          gap_d = gap_q - 1'b1;
          if (gap_q == GW'(1)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    key_ready_d  = pop;
    key_stroke_d = key_stroke_q;
    key_code_d   = key_code_q;
    if (pop) {key_stroke_d, key_code_d} = mem_q[rd_ptr_q];
  end

  assign key_ready  = key_ready_q;
  assign key_stroke = key_stroke_q;
  assign key_code   = key_code_q;
  assign overflow   = overflow_q;
  assign level      = count_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Randomized and directed bench for key_event_queue against a queue-based timing model.
module tb_key_event_queue;
  localparam int unsigned DL    = 3;
  localparam int unsigned G     = 20;
  localparam int unsigned DEPTH = 1 << DL;

  logic        clk_sys = 1'b0;
  logic        res_n   = 1'b1;
  logic        flush   = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        key_ready, key_stroke, overflow;
  logic [9:0]  key_code;
  logic [DL:0] level;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  typedef struct { int unsigned cyc; logic [10:0] d; } del_t;
  del_t obs_q[$];
  del_t exp_q[$];

  logic [10:0] m_q[$];
  int unsigned m_cyc = 0;
  int unsigned m_next_ok = 0;
  bit          m_armed, m_prev, m_ovf, m_hv;
  logic [8:0]  m_hc;
  bit          exp_ready;
  logic        exp_stroke;
  logic [9:0]  exp_code;
  logic [DL:0] exp_lvl;

  key_event_queue #(.DEPTH_LOG2(DL), .GAP_CYCLES(G)) dut (
    .clk_sys   (clk_sys),
    .res_n     (res_n),
    .flush     (flush),
    .ps2_key   (ps2_key),
    .key_ready (key_ready),
    .key_stroke(key_stroke),
    .key_code  (key_code),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic model_reset();
    m_q.delete();
    m_next_ok = 0; m_armed = 0; m_prev = 0; m_ovf = 0; m_hv = 0; m_hc = '0;
    exp_ready = 0; exp_stroke = 0; exp_code = '0; exp_lvl = '0;
  endtask

  // Advance one clock edge: update the model from the pre-edge inputs, then log any DUT strobe.
  task automatic tick();
    int unsigned e = m_cyc;
    logic [10:0] ent;
    bit accept;
    exp_ready = 1'b0;
    if (flush) begin
      m_q.delete(); m_ovf = 0; m_armed = 0; m_hv = 0; m_next_ok = 0;
    end else begin
      if (m_q.size() != 0 && e >= m_next_ok) begin
        ent = m_q.pop_front();
        exp_ready = 1'b1; exp_stroke = ent[10]; exp_code = ent[9:0];
        m_next_ok = e + G;
        exp_q.push_back('{e, ent});
      end
      if (!m_armed) begin
        m_armed = 1; m_prev = ps2_key[10];
      end else if (ps2_key[10] != m_prev) begin
        m_prev = ps2_key[10];
        accept = 1'b1;
`ifdef KEY_REPEAT_FILTER_EN
        if (ps2_key[9]) begin
          if (m_hv && m_hc == ps2_key[8:0]) accept = 1'b0;
          else begin m_hc = ps2_key[8:0]; m_hv = 1'b1; end
        end else if (m_hv && m_hc == ps2_key[8:0]) m_hv = 1'b0;
`endif
        if (accept) begin
          if (m_q.size() < DEPTH) m_q.push_back({~ps2_key[9], 1'b0, ps2_key[8:0]});
          else m_ovf = 1'b1;
        end
      end
    end
    exp_lvl = (DL+1)'(m_q.size());
    m_cyc++;
    @(posedge clk_sys);
    #1;
    if (key_ready === 1'b1) obs_q.push_back('{e, {key_stroke, key_code}});
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input bit make, input bit ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], make, ext, code};
  endtask

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    model_reset();
    #2;
    n_tot++; if (key_ready !== 1'b0) $display("FAIL reset_ready actual=%b expected=0", key_ready); else n_pass++;
    n_tot++; if (key_stroke !== 1'b0) $display("FAIL reset_stroke actual=%b expected=0", key_stroke); else n_pass++;
    n_tot++; if (key_code !== 10'h000) $display("FAIL reset_code actual=%h expected=000", key_code); else n_pass++;
    n_tot++; if (overflow !== 1'b0) $display("FAIL reset_overflow actual=%b expected=0", overflow); else n_pass++;
    n_tot++; if (level !== '0) $display("FAIL reset_level actual=%0d expected=0", level); else n_pass++;
    @(negedge clk_sys);
    res_n = 1'b1;
  endtask

  task automatic test_single();
    int unsigned e1;
    clear_logs();
    tick();
    drive(1'b1, 1'b0, 8'h1C);
    e1 = m_cyc;
    run(4);
    n_tot++; if (obs_q.size() != 1) $display("FAIL single_count actual=%0d expected=1", obs_q.size()); else n_pass++;
    if (obs_q.size() >= 1) begin
      n_tot++; if (obs_q[0].cyc != e1 + 1) $display("FAIL single_latency actual=%0d expected=%0d", obs_q[0].cyc, e1 + 1); else n_pass++;
      n_tot++; if (obs_q[0].d !== 11'h01C) $display("FAIL single_data actual=%h expected=01c", obs_q[0].d); else n_pass++;
    end
    n_tot++; if (level !== '0) $display("FAIL single_level actual=%0d expected=0", level); else n_pass++;
  endtask

  task automatic test_pacing();
    logic [7:0] codes [3] = '{8'h16, 8'h1E, 8'h26};
    int unsigned e1;
    logic [DL:0] peak = '0;
    run(G);
    clear_logs();
    e1 = m_cyc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, codes[i]);
      tick();
      if (level > peak) peak = level;
    end
    run(3 * G);
    n_tot++; if (obs_q.size() != 3) $display("FAIL pacing_count actual=%0d expected=3", obs_q.size()); else n_pass++;
    if (obs_q.size() == 3) begin
      n_tot++; if (obs_q[0].cyc != e1 + 1) $display("FAIL pacing_first actual=%0d expected=%0d", obs_q[0].cyc, e1 + 1); else n_pass++;
      for (int i = 1; i < 3; i++) begin
        n_tot++; if (obs_q[i].cyc - obs_q[i-1].cyc != G) $display("FAIL pacing_gap%0d actual=%0d expected=%0d", i, obs_q[i].cyc - obs_q[i-1].cyc, G); else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
        n_tot++; if (obs_q[i].d !== {3'b000, codes[i]}) $display("FAIL pacing_code%0d actual=%h expected=%h", i, obs_q[i].d, {3'b000, codes[i]}); else n_pass++;
      end
    end
    n_tot++; if (peak != 2 && peak != 3) $display("FAIL pacing_peak actual=%0d expected=2or3", peak); else n_pass++;
  endtask

  task automatic test_extended_break();
    run(G);
    clear_logs();
    drive(1'b0, 1'b1, 8'h75);
    run(4);
    n_tot++; if (obs_q.size() != 1) $display("FAIL ext_count actual=%0d expected=1", obs_q.size()); else n_pass++;
    n_tot++; if (key_stroke !== 1'b1) $display("FAIL ext_stroke actual=%b expected=1", key_stroke); else n_pass++;
    n_tot++; if (key_code !== 10'h175) $display("FAIL ext_code actual=%h expected=175", key_code); else n_pass++;
  endtask

  task automatic test_repeat();
    int unsigned want;
`ifdef KEY_REPEAT_FILTER_EN
    want = 3;
`else
    want = 7;
`endif
    run(G);
    clear_logs();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 8'h1C); tick(); end
    drive(1'b0, 1'b0, 8'h1C); tick();
    drive(1'b1, 1'b0, 8'h1C); tick();
    run(8 * G);
    n_tot++; if (obs_q.size() != want) $display("FAIL repeat_count actual=%0d expected=%0d", obs_q.size(), want); else n_pass++;
    n_tot++; if (exp_q.size() != obs_q.size()) $display("FAIL repeat_model actual=%0d expected=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tot++; if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].d !== exp_q[i].d)
        $display("FAIL repeat_del%0d actual=%0d:%h expected=%0d:%h", i, obs_q[i].cyc, obs_q[i].d, exp_q[i].cyc, exp_q[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_overflow_flush();
    run(G);
    clear_logs();
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'($urandom), 8'($urandom)); tick(); end
    n_tot++; if (overflow !== 1'b1) $display("FAIL ovf_sticky actual=%b expected=1", overflow); else n_pass++;
    n_tot++; if (level !== DEPTH) $display("FAIL ovf_level actual=%0d expected=%0d", level, DEPTH); else n_pass++;
    run(10 * G);
    n_tot++; if (obs_q.size() != 9) $display("FAIL ovf_delivered actual=%0d expected=9", obs_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tot++; if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].d !== exp_q[i].d)
        $display("FAIL ovf_del%0d actual=%0d:%h expected=%0d:%h", i, obs_q[i].cyc, obs_q[i].d, exp_q[i].cyc, exp_q[i].d);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 8'h30 + 8'(i)); tick(); end
    flush = 1'b1;
    drive(1'b1, 1'b0, 8'h44);
    tick();
    flush = 1'b0;
    n_tot++; if (overflow !== 1'b0) $display("FAIL flush_overflow actual=%b expected=0", overflow); else n_pass++;
    n_tot++; if (level !== '0) $display("FAIL flush_level actual=%0d expected=0", level); else n_pass++;
    n_tot++; if (key_code !== exp_code) $display("FAIL flush_code_hold actual=%h expected=%h", key_code, exp_code); else n_pass++;
    clear_logs();
    run(3 * G);
    n_tot++; if (obs_q.size() != 0) $display("FAIL flush_quiet actual=%0d expected=0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_async_reset();
    int unsigned k = 0;
    run(G);
    for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b0, 8'h50 + 8'(i)); tick(); end
    while (key_ready !== 1'b1 && k < 2 * G) begin tick(); k++; end
    n_tot++; if (key_ready !== 1'b1) $display("FAIL areset_strobe_wait actual=%b expected=1", key_ready); else n_pass++;
    n_tot++; if (level !== 4) $display("FAIL areset_pre_level actual=%0d expected=4", level); else n_pass++;
    res_n = 1'b0;
    model_reset();
    #2;
    n_tot++; if (key_ready !== 1'b0) $display("FAIL areset_ready actual=%b expected=0", key_ready); else n_pass++;
    n_tot++; if (level !== '0) $display("FAIL areset_level actual=%0d expected=0", level); else n_pass++;
    n_tot++; if (key_code !== 10'h000) $display("FAIL areset_code actual=%h expected=000", key_code); else n_pass++;
    drive(1'b1, 1'b0, 8'h5A);
    @(negedge clk_sys);
    res_n = 1'b1;
    clear_logs();
    run(2 * G);
    n_tot++; if (obs_q.size() != 0) $display("FAIL areset_arm_only actual=%0d expected=0", obs_q.size()); else n_pass++;
    drive(1'b1, 1'b0, 8'h5B);
    run(4);
    n_tot++; if (obs_q.size() != 1) $display("FAIL areset_resume actual=%0d expected=1", obs_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      flush = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) drive(1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)));
      tick();
      n_tot++; if (key_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d actual=%b expected=%b", i, key_ready, exp_ready); else n_pass++;
      n_tot++; if ({key_stroke, key_code} !== {exp_stroke, exp_code}) $display("FAIL rnd_data cyc=%0d actual=%h expected=%h", i, {key_stroke, key_code}, {exp_stroke, exp_code}); else n_pass++;
      n_tot++; if (level !== exp_lvl) $display("FAIL rnd_level cyc=%0d actual=%0d expected=%0d", i, level, exp_lvl); else n_pass++;
      n_tot++; if (overflow !== m_ovf) $display("FAIL rnd_overflow cyc=%0d actual=%b expected=%b", i, overflow, m_ovf); else n_pass++;
    end
    flush = 1'b0;
    n_tot++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count actual=%0d expected=%0d", obs_q.size(), exp_q.size()); else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_pacing();
    test_extended_break();
    test_repeat();
    test_overflow_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
